mfp_ahb_sevensegscan: RTL and testbench

Parametrised multiplexed seven-segment display scanner. It supersedes the fixed 8-digit timer with configurable digit count, per-digit enable, decimal points, PWM brightness, blink and frame-sync output. It sits between the AHB GPIO register block and the board anode and cathode pins. It is driven from the system clock and has no bus interface of its own.

---
 rtl/mfp_ahb_sevensegscan.sv | 152 +++++++++++++++
 tb/tb_mfp_ahb_sevensegscan.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_ahb_sevensegscan.sv
// Multiplexed seven-segment scanner: per-digit enable, DP, PWM, blink, frame tick.
// Optional leading-zero blanking is built when MFP_SEVENSEG_LZB_EN is defined.
module mfp_ahb_sevensegscan #(
    parameter int NDIGITS     = 8,
    parameter int DIV_WIDTH   = 16,
    parameter int BRIGHT_BITS = 4,
    parameter int BLINK_LOG2  = 5
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NDIGITS-1:0]     EN,
    input  logic [4*NDIGITS-1:0]   DIGITS,
    input  logic [NDIGITS-1:0]     DP,
    input  logic [NDIGITS-1:0]     BLINK,
    input  logic [BRIGHT_BITS-1:0] BRIGHT,
    output logic [NDIGITS-1:0]     DISPENOUT,
    output logic [6:0]             DISPOUT,
    output logic                   DISPDP,
    output logic                   FRAME_TICK
);

    localparam int IW = $clog2(NDIGITS);
    localparam logic [IW-1:0] LAST = IW'(NDIGITS - 1);

    logic [DIV_WIDTH-1:0]   presc_q, presc_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [BLINK_LOG2-1:0]  frame_q, frame_d;
    logic                   phase_q, phase_d;
    logic [BRIGHT_BITS-1:0] bright_q, bright_d;
    logic                   wrap_q, wrap_d;

    logic [NDIGITS-1:0]     en_n_q, en_n_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;
    logic                   tick_q, tick_d;

    logic                   slot_end;
    logic                   pwm_on;
    logic                   lzb;
    logic                   visible;
    logic [3:0]             nib;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Scan timing: prescaler, digit index, frame counter, blink phase, brightness latch
    always_comb begin
        slot_end = &presc_q;
        presc_d  = presc_q + 1'b1;
        idx_d    = idx_q;
        frame_d  = frame_q;
        phase_d  = phase_q;
        bright_d = bright_q;
        wrap_d   = 1'b0;
        if (slot_end) begin
            bright_d = BRIGHT;
            if (idx_q == LAST) begin
                idx_d   = '0;
                wrap_d  = 1'b1;
                frame_d = frame_q + 1'b1;
                if (&frame_q) begin
                    phase_d = ~phase_q;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

`ifdef MFP_SEVENSEG_LZB_EN
    // Blank a non-zero-position digit when it and every higher digit are 0 without DP
    always_comb begin
        lzb = (idx_q != '0);
        for (int j = 0; j < NDIGITS; j++) begin
            if (j >= int'(idx_q) && (DIGITS[4*j +: 4] != 4'h0 || DP[j])) begin
                lzb = 1'b0;
            end
        end
    end
`else
    assign lzb = 1'b0;
`endif

    // Pin values for the current slot position, registered one cycle later
    always_comb begin
        nib     = DIGITS[{idx_q, 2'b00} +: 4];
        pwm_on  = presc_q[DIV_WIDTH-1 -: BRIGHT_BITS] <= bright_q;
        visible = EN[idx_q] & ~(BLINK[idx_q] & phase_q) & ~lzb & pwm_on;
        en_n_d  = '1;
        seg_d   = 7'h7F;
        dp_d    = 1'b1;
        tick_d  = wrap_q;
        if (visible) begin
            en_n_d[idx_q] = 1'b0;
            seg_d         = hex7(nib);
            dp_d          = ~DP[idx_q];
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q  <= '0;
            idx_q    <= '0;
            frame_q  <= '0;
            phase_q  <= 1'b0;
            bright_q <= '1;
            wrap_q   <= 1'b0;
            en_n_q   <= '1;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            phase_q  <= phase_d;
            bright_q <= bright_d;
            wrap_q   <= wrap_d;
            en_n_q   <= en_n_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            tick_q   <= tick_d;
        end
    end

    assign DISPENOUT  = en_n_q;
    assign DISPOUT    = seg_q;
    assign DISPDP     = dp_q;
    assign FRAME_TICK = tick_q;

endmodule

// File: tb/tb_mfp_ahb_sevensegscan.sv
// Bench for mfp_ahb_sevensegscan with NDIGITS=4, DIV_WIDTH=4, BRIGHT_BITS=4, BLINK_LOG2=1.
// Expectations follow MFP_SEVENSEG_LZB_EN the same way as the design.
module tb_mfp_ahb_sevensegscan;

    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg;
    } vec_t;

    typedef struct {
        int         t;
        logic [3:0] en_n;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  EN = 4'hF;
    logic [15:0] DIGITS = 16'h3210;
    logic [3:0]  DP = 4'h0;
    logic [3:0]  BLINK = 4'h0;
    logic [3:0]  BRIGHT = 4'hF;
    logic [3:0]  DISPENOUT;
    logic [6:0]  DISPOUT;
    logic        DISPDP;
    logic        FRAME_TICK;

    int   total = 0;
    int   bad = 0;
    vec_t vecs[16];
    exp_t sbq[$];
    int   t = 0;
    int   cur_t = -1;
    logic [3:0] lat = 4'hF;
    bit   run = 0;

    mfp_ahb_sevensegscan #(
        .NDIGITS(4), .DIV_WIDTH(4), .BRIGHT_BITS(4), .BLINK_LOG2(1)
    ) dut (
        .clk(clk), .resetn(resetn), .EN(EN), .DIGITS(DIGITS), .DP(DP),
        .BLINK(BLINK), .BRIGHT(BRIGHT), .DISPENOUT(DISPENOUT),
        .DISPOUT(DISPOUT), .DISPDP(DISPDP), .FRAME_TICK(FRAME_TICK)
    );

    always #5 clk = ~clk;

    // Expected pins for scan position t (cycles since reset release)
    function automatic exp_t model(int tt, logic [3:0] lb, logic [3:0] en,
                                   logic [15:0] dig, logic [3:0] dp,
                                   logic [3:0] blk);
        exp_t e;
        int pr = tt % 16;
        int ix = (tt / 16) % 4;
        int fr = tt / 64;
        bit ph = ((fr / 2) % 2) == 1;
        bit vis = en[ix] && !(blk[ix] && ph) && (pr <= int'(lb));
`ifdef MFP_SEVENSEG_LZB_EN
        if (ix > 0) begin
            bit z = 1;
            for (int j = ix; j < 4; j++)
                if (dig[4*j +: 4] != 4'h0 || dp[j]) z = 0;
            if (z) vis = 0;
        end
`endif
        e.t    = tt;
        e.en_n = 4'hF;
        e.seg  = 7'h7F;
        e.dp   = 1'b1;
        e.tick = (tt > 0) && (tt % 64 == 0);
        if (vis) begin
            e.en_n = 4'hF & ~(4'b0001 << ix);
            e.seg  = vecs[dig[4*ix +: 4]].seg;
            e.dp   = ~dp[ix];
        end
        return e;
    endfunction

    // Push the expected result for every scanned cycle
    always @(posedge clk) begin
        if (run && resetn) begin
            sbq.push_back(model(t, lat, EN, DIGITS, DP, BLINK));
            if (t % 16 == 15) lat = BRIGHT;
            t++;
        end
    end

    // Pop and compare once the registered outputs have settled
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            cur_t = e.t;
            total++;
            if ({DISPENOUT, DISPOUT, DISPDP, FRAME_TICK} !==
                {e.en_n, e.seg, e.dp, e.tick}) begin
                bad++;
                $display("FAIL sb t=%0d got en=%b seg=%h dp=%b tick=%b want en=%b seg=%h dp=%b tick=%b",
                         e.t, DISPENOUT, DISPOUT, DISPDP, FRAME_TICK,
                         e.en_n, e.seg, e.dp, e.tick);
            end
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic chk_rst(string name);
        chk({name, "_en"}, 32'(DISPENOUT), 32'hF);
        chk({name, "_seg"}, 32'(DISPOUT), 32'h7F);
        chk({name, "_dp"}, 32'(DISPDP), 32'h1);
        chk({name, "_tick"}, 32'(FRAME_TICK), 32'h0);
    endtask

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Stop on the last cycle of a slot; slot<0 accepts any following slot
    task automatic sync_slot(int slot);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(cur_t % 16 == 15 &&
                     (slot < 0 || ((cur_t / 16) + 1) % 4 == slot)) && n < 300);
        if (n >= 300) chk("sync_timeout", 32'(n), 32'd0);
    endtask

    // Count lit cycles over the next full slot, optionally changing BRIGHT mid-slot
    task automatic count_lit(int chg_at, logic [3:0] nb, output int n);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            #1;
            if (DISPENOUT !== 4'hF) n++;
            if (i == chg_at) BRIGHT = nb;
        end
    endtask

    task automatic release_rst();
        sbq.delete();
        t = 0;
        lat = 4'hF;
        run = 1;
        resetn = 1'b1;
        #1;
    endtask

    initial begin
        int n;
        int m;
        vecs[0]  = '{4'h0, 7'h40};  vecs[1]  = '{4'h1, 7'h79};
        vecs[2]  = '{4'h2, 7'h24};  vecs[3]  = '{4'h3, 7'h30};
        vecs[4]  = '{4'h4, 7'h19};  vecs[5]  = '{4'h5, 7'h12};
        vecs[6]  = '{4'h6, 7'h02};  vecs[7]  = '{4'h7, 7'h78};
        vecs[8]  = '{4'h8, 7'h00};  vecs[9]  = '{4'h9, 7'h10};
        vecs[10] = '{4'hA, 7'h08};  vecs[11] = '{4'hB, 7'h03};
        vecs[12] = '{4'hC, 7'h46};  vecs[13] = '{4'hD, 7'h21};
        vecs[14] = '{4'hE, 7'h06};  vecs[15] = '{4'hF, 7'h0E};

        cycles(3);
        chk_rst("reset");
        release_rst();
        chk_rst("first");
        cycles(140);

        for (int i = 0; i < 16; i++) begin
            DIGITS = {4{vecs[i].nib}};
            DP = 4'hF;
            cycles(1);
            chk($sformatf("hex%0h", vecs[i].nib), 32'(DISPOUT), 32'(vecs[i].seg));
        end
        DIGITS = 16'h3210;
        DP = 4'h0;

        BRIGHT = 4'h0;
        sync_slot(-1);
        count_lit(-1, 4'h0, n);
        chk("duty_b0", 32'(n), 32'd1);
        BRIGHT = 4'h7;
        sync_slot(-1);
        count_lit(3, 4'hF, n);
        chk("duty_b7", 32'(n), 32'd8);
        count_lit(-1, 4'hF, n);
        chk("duty_next", 32'(n), 32'd16);

        EN = 4'b1011;
        DP = 4'b0001;
        sync_slot(2);
        cycles(1);
        chk("en_off_en", 32'(DISPENOUT), 32'hF);
        chk("en_off_seg", 32'(DISPOUT), 32'h7F);
        chk("en_off_dp", 32'(DISPDP), 32'h1);
        sync_slot(0);
        cycles(1);
        chk("dp0_en", 32'(DISPENOUT), 32'hE);
        chk("dp0_dp", 32'(DISPDP), 32'h0);
        EN = 4'hF;
        DP = 4'h0;

        BLINK = 4'b0010;
        cycles(320);
        BLINK = 4'h0;

        sync_slot(2);
        cycles(3);
        #1;
        run = 0;
        resetn = 1'b0;
        #1;
        chk_rst("midrst");
        cycles(3);
        chk_rst("held");
        release_rst();
        chk_rst("rel");
        m = 0;
        for (int i = 0; i < 16; i++) begin
            cycles(1);
            if (DISPENOUT === 4'b1110) m++;
        end
        chk("slot0_len", 32'(m), 32'd16);
        cycles(1);
        chk("slot1_start", 32'(DISPENOUT), 32'hD);

        DIGITS = 16'h0050;
        cycles(70);
        DIGITS = 16'h0000;
        cycles(70);
        DP = 4'b1000;
        cycles(70);

        cycles(2);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
